// File: rtl/pc_fetch_queue.sv
// Fetch front end: owns the fetch PC, issues one ibus request at a time and
// buffers returned instructions (or a misaligned-PC exception) for decode.
module pc_fetch_queue #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] STEP     = 64'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_except,
  output logic [4:0]  out_ecode
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT     = CNT_W'(DEPTH);
  localparam logic [4:0]       ECODE_MISALIGN = 5'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // may issue
    WAIT = 2'd1,  // address accepted, data pending
    DROP = 2'd2,  // in-flight data belongs to a flushed stream
    HALT = 2'd3   // misaligned PC reported, wait for redirect
  } state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        except;
    logic [4:0]  ecode;
  } entry_t;

  state_e           state_q, state_d;
  logic [63:0]      pc_q, pc_d;
  logic [63:0]      inflight_pc_q, inflight_pc_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  entry_t           mem_q [DEPTH];

  logic   has_space;
  logic   pc_aligned;
  logic   misalign_fire;
  logic   accept;
  logic   push;
  logic   pop;
  entry_t push_entry;
  entry_t head_entry;

  assign has_space  = (count_q < FULL_COUNT);
  assign pc_aligned = (pc_q[1:0] == 2'b00);
  assign accept     = ireq_valid && iresp_addr_ok;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its peers regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      unique case (state_q)
        IDLE:    state_d = (accept && !iresp_data_ok) ? DROP : IDLE;
        WAIT:    state_d = iresp_data_ok ? IDLE : DROP;
        DROP:    state_d = iresp_data_ok ? IDLE : DROP;
        HALT:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = iresp_data_ok ? IDLE : WAIT;
          end else if (misalign_fire) begin
            state_d = HALT;
          end
        end
        WAIT:    state_d = iresp_data_ok ? IDLE : WAIT;
        DROP:    state_d = iresp_data_ok ? IDLE : DROP;
        HALT:    state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (registered state only, no path from iresp_*)
  // ---------------------------------------------------------------------------
  always_comb begin
    ireq_valid    = 1'b0;
    misalign_fire = 1'b0;
    if (state_q == IDLE && has_space) begin
      ireq_valid    = pc_aligned;
      misalign_fire = !pc_aligned;
    end
  end

  assign ireq_addr = pc_q;

  // ---------------------------------------------------------------------------
  // Queue push/pop and PC datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    push          = 1'b0;
    push_entry    = '0;
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;

    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else begin
      if (accept) begin
        inflight_pc_d = pc_q;
        pc_d          = pc_q + STEP;
      end

      if (accept && iresp_data_ok) begin
        push       = 1'b1;
        push_entry = '{pc: pc_q, instr: iresp_data, except: 1'b0, ecode: 5'd0};
      end else if (state_q == WAIT && iresp_data_ok) begin
        push       = 1'b1;
        push_entry = '{pc: inflight_pc_q, instr: iresp_data, except: 1'b0, ecode: 5'd0};
      end else if (misalign_fire) begin
        push       = 1'b1;
        push_entry = '{pc: pc_q, instr: 32'd0, except: 1'b1, ecode: ECODE_MISALIGN};
      end
    end
  end

  assign pop = out_valid && out_ready && !redirect_valid;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (redirect_valid) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Pointers are exactly log2(DEPTH) wide, so increment wraps for free.
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_pc_q <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

  // NOTE: storage is not reset; out_* are masked by out_valid, so stale
  // entries are never observable and the array can map to plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= push_entry;
    end
  end

  // ---------------------------------------------------------------------------
  // Decode-facing head of queue
  // ---------------------------------------------------------------------------
  assign head_entry = mem_q[head_q];
  assign out_valid  = (count_q != '0);
  assign out_pc     = out_valid ? head_entry.pc     : 64'd0;
  assign out_instr  = out_valid ? head_entry.instr  : 32'd0;
  assign out_except = out_valid ? head_entry.except : 1'b0;
  assign out_ecode  = out_valid ? head_entry.ecode  : 5'd0;

endmodule

// File: tb/tb_pc_fetch_queue.sv
// Directed scenarios plus randomized bus/redirect traffic for pc_fetch_queue,
// checked every cycle against a transaction-level queue model.
module tb_pc_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  localparam logic [63:0] STEP     = 64'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok = 1'b0;
  logic        iresp_data_ok = 1'b0;
  logic [31:0] iresp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_except;
  logic [4:0]  out_ecode;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .STEP(STEP)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_addr_ok  (iresp_addr_ok),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_except     (out_except),
    .out_ecode      (out_ecode)
  );

  // Reference model: a list of fetched entries plus one outstanding-request
  // record (with a "stale" mark after a flush) and a halted flag.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        exc;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] m_pc;
  bit          m_busy;
  logic [63:0] m_busy_pc;
  bit          m_stale;
  bit          m_halt;

  function automatic bit m_req();
    return !m_busy && !m_halt && (m_pc[1:0] == 2'b00) && (mq.size() < DEPTH);
  endfunction

  function automatic logic [31:0] instr_for(logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    ent_t e;
    e = '0;
    if (mq.size() != 0) e = mq[0];
    check("m_ireq_valid", {63'd0, ireq_valid}, {63'd0, m_req()});
    if (m_req()) check("m_ireq_addr", ireq_addr, m_pc);
    check("m_out_valid", {63'd0, out_valid}, {63'd0, mq.size() != 0});
    check("m_out_pc", out_pc, e.pc);
    check("m_out_instr", {32'd0, out_instr}, {32'd0, e.instr});
    check("m_out_except", {63'd0, out_except}, {63'd0, e.exc});
    check("m_out_ecode", {59'd0, out_ecode}, 64'd0);
  endtask

  task automatic model_step();
    bit req, acc, do_pop, misal;
    req = m_req();
    if (reset) begin
      m_pc = RESET_PC; mq.delete(); m_busy = 0; m_stale = 0; m_halt = 0;
      return;
    end
    acc = req && iresp_addr_ok;
    if (redirect_valid) begin
      if (acc && !iresp_data_ok) begin
        m_busy = 1; m_stale = 1;
      end else if (m_busy && !iresp_data_ok) begin
        m_stale = 1;
      end else if (m_busy && iresp_data_ok) begin
        m_busy = 0; m_stale = 0;
      end
      mq.delete();
      m_halt = 0;
      m_pc   = redirect_pc;
      return;
    end
    do_pop = (mq.size() != 0) && out_ready;
    misal  = !m_busy && !m_halt && (m_pc[1:0] != 2'b00) && (mq.size() < DEPTH);
    if (do_pop) void'(mq.pop_front());
    if (acc) begin
      if (iresp_data_ok) mq.push_back('{m_pc, iresp_data, 1'b0});
      else begin m_busy = 1; m_busy_pc = m_pc; end
      m_pc = m_pc + STEP;
    end else if (m_busy && iresp_data_ok) begin
      if (!m_stale) mq.push_back('{m_busy_pc, iresp_data, 1'b0});
      m_busy = 0; m_stale = 0;
    end else if (misal) begin
      mq.push_back('{m_pc, 32'd0, 1'b1});
      m_halt = 1;
    end
  endtask

  // One clock: compare, advance model with the inputs the DUT will sample,
  // then move to 1 time unit after the edge.
  task automatic cycle();
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    redirect_valid = 0; iresp_addr_ok = 0; iresp_data_ok = 0; iresp_data = '0;
  endtask

  task automatic zero_wait();
    redirect_valid = 0;
    iresp_addr_ok  = m_req();
    iresp_data_ok  = m_req();
    iresp_data     = instr_for(m_pc);
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    cycle();
    reset = 0;
  endtask

  initial begin
    // Initial reset: DUT state is unknown, so no comparisons before it.
    idle_inputs();
    reset = 1;
    @(posedge clk);
    @(posedge clk);
    m_pc = RESET_PC; m_busy = 0; m_stale = 0; m_halt = 0; m_busy_pc = '0;
    #1;
    reset = 0;

    // Reset state
    check("rst_ireq_valid", {63'd0, ireq_valid}, 64'd1);
    check("rst_ireq_addr", ireq_addr, 64'h8000_0000);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_pc", out_pc, 64'd0);
    check("rst_out_instr", {32'd0, out_instr}, 64'd0);
    check("rst_out_except", {63'd0, out_except}, 64'd0);
    check("rst_out_ecode", {59'd0, out_ecode}, 64'd0);

    // Zero-wait bus, decode always ready
    out_ready = 1;
    zero_wait(); cycle();
    check("seq0_pc", out_pc, 64'h8000_0000);
    check("seq0_instr", {32'd0, out_instr}, {32'd0, instr_for(64'h8000_0000)});
    zero_wait(); cycle();
    check("seq1_pc", out_pc, 64'h8000_0004);
    zero_wait(); cycle();
    check("seq2_pc", out_pc, 64'h8000_0008);

    // Fill with decode stalled, then drain
    do_reset();
    out_ready = 0;
    repeat (4) begin zero_wait(); cycle(); end
    check("full_ireq_valid", {63'd0, ireq_valid}, 64'd0);
    check("full_head_pc", out_pc, 64'h8000_0000);
    zero_wait(); cycle();
    check("full_ireq_valid_hold", {63'd0, ireq_valid}, 64'd0);
    out_ready = 1;
    zero_wait(); cycle();
    check("drain0_pc", out_pc, 64'h8000_0004);
    check("resume_valid", {63'd0, ireq_valid}, 64'd1);
    check("resume_addr", ireq_addr, 64'h8000_0010);
    zero_wait(); cycle();
    check("drain1_pc", out_pc, 64'h8000_0008);
    zero_wait(); cycle();
    check("drain2_pc", out_pc, 64'h8000_000C);
    zero_wait(); cycle();
    check("drain3_pc", out_pc, 64'h8000_0010);

    // Redirect while waiting for data; late data must be discarded
    do_reset();
    out_ready = 1;
    idle_inputs(); iresp_addr_ok = 1; cycle();
    check("wait_no_req", {63'd0, ireq_valid}, 64'd0);
    idle_inputs(); redirect_valid = 1; redirect_pc = 64'h8000_1000; cycle();
    idle_inputs(); cycle(); cycle();
    check("drop_no_req", {63'd0, ireq_valid}, 64'd0);
    iresp_data_ok = 1; iresp_data = 32'hDEAD_BEEF; cycle();
    idle_inputs();
    check("drop_out_valid", {63'd0, out_valid}, 64'd0);
    check("drop_resume_valid", {63'd0, ireq_valid}, 64'd1);
    check("drop_resume_addr", ireq_addr, 64'h8000_1000);
    cycle();
    check("drop_out_valid_late", {63'd0, out_valid}, 64'd0);

    // Redirect coincident with data_ok in WAIT, two entries queued
    do_reset();
    out_ready = 0;
    repeat (2) begin zero_wait(); cycle(); end
    idle_inputs(); iresp_addr_ok = 1; cycle();
    check("wait2_out_valid", {63'd0, out_valid}, 64'd1);
    idle_inputs();
    redirect_valid = 1; redirect_pc = 64'h8000_2000;
    iresp_data_ok = 1; iresp_data = 32'hCAFE_F00D;
    cycle();
    idle_inputs();
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    check("flush_ireq_valid", {63'd0, ireq_valid}, 64'd1);
    check("flush_ireq_addr", ireq_addr, 64'h8000_2000);
    cycle();
    check("flush_out_valid_after", {63'd0, out_valid}, 64'd0);

    // Misaligned redirect target
    idle_inputs(); redirect_valid = 1; redirect_pc = 64'h8000_0002; cycle();
    idle_inputs();
    check("mis_no_req", {63'd0, ireq_valid}, 64'd0);
    cycle();
    check("mis_out_valid", {63'd0, out_valid}, 64'd1);
    check("mis_out_pc", out_pc, 64'h8000_0002);
    check("mis_out_except", {63'd0, out_except}, 64'd1);
    check("mis_out_ecode", {59'd0, out_ecode}, 64'd0);
    check("mis_out_instr", {32'd0, out_instr}, 64'd0);
    check("mis_no_req_halt", {63'd0, ireq_valid}, 64'd0);
    repeat (3) cycle();
    check("halt_no_req", {63'd0, ireq_valid}, 64'd0);
    redirect_valid = 1; redirect_pc = 64'h8000_0100; cycle();
    idle_inputs();
    check("unhalt_out_valid", {63'd0, out_valid}, 64'd0);
    check("unhalt_ireq_valid", {63'd0, ireq_valid}, 64'd1);
    check("unhalt_ireq_addr", ireq_addr, 64'h8000_0100);
    zero_wait(); cycle();
    check("unhalt_first_pc", out_pc, 64'h8000_0100);

    // Reset in WAIT with three entries queued
    do_reset();
    out_ready = 0;
    repeat (3) begin zero_wait(); cycle(); end
    idle_inputs(); iresp_addr_ok = 1; cycle();
    check("wait3_out_valid", {63'd0, out_valid}, 64'd1);
    idle_inputs(); reset = 1; cycle(); reset = 0;
    check("rst_wait_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_wait_ireq_valid", {63'd0, ireq_valid}, 64'd1);
    check("rst_wait_ireq_addr", ireq_addr, 64'h8000_0000);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit acc;
      reset          = ($urandom_range(0, 199) == 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
      else redirect_pc = {$urandom, $urandom} & ~64'd3;
      if ($urandom_range(0, 7) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
      out_ready     = ($urandom_range(0, 9) < 6);
      iresp_addr_ok = ($urandom_range(0, 2) != 0);
      iresp_data    = $urandom;
      acc = m_req() && iresp_addr_ok;
      if (m_busy) iresp_data_ok = ($urandom_range(0, 2) == 0);
      else if (acc) iresp_data_ok = ($urandom_range(0, 2) == 0);
      else iresp_data_ok = 0;
      cycle();
    end
    reset = 0;
    idle_inputs();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_queue.md
# pc_fetch_queue

Parametrised fetch front end that replaces the single-register PC stage. It owns the fetch PC and issues instruction-bus requests through a split address/data handshake with at most one request in flight. Returned instructions are buffered in a DEPTH-entry queue for decode. Redirects flush the queue and discard in-flight data, and a misaligned PC is reported as an in-order exception entry instead of being fetched.

## Interface
Parameters:
- RESET_PC, 64'h8000_0000, PC loaded on reset
- DEPTH, 4, queue entries; power of two, 2..16
- STEP, 4, byte increment between sequential fetches

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- redirect_valid  in  1  flush request (exception/branch resolve)
- redirect_pc  in  64  new fetch PC
- ireq_valid  out  1  bus request valid
- ireq_addr  out  64  bus request address
- iresp_addr_ok  in  1  request accepted this cycle
- iresp_data_ok  in  1  instruction returned this cycle
- iresp_data  in  32  instruction word
- out_valid  out  1  queue head valid
- out_ready  in  1  decode consumes head
- out_pc  out  64  head PC
- out_instr  out  32  head instruction (0 for exception entries)
- out_except  out  1  head is a misaligned-fetch exception
- out_ecode  out  5  exception code; 5'd0 for misaligned fetch, else 0

## Operation
- Registers: pc, inflight_pc, state, queue storage, head, tail, count (0..DEPTH). Head and tail wrap modulo DEPTH.
- States:
  - IDLE: may issue.
  - WAIT: address accepted, data pending.
  - DROP: in-flight data to discard.
  - HALT: misaligned PC reported.
- IDLE, aligned pc, count<DEPTH:
  - ireq_valid=1 and ireq_addr=pc.
  - On addr_ok: inflight_pc<=pc, pc<=pc+STEP (64-bit wrap), go to WAIT.
  - If data_ok is in the same cycle as addr_ok: push {pc, iresp_data}, stay in IDLE.
- IDLE, count==DEPTH: ireq_valid=0. Address and valid are not required to be held across cycles where the queue fills.
- IDLE, pc[1:0]!=0, count<DEPTH:
  - ireq_valid=0.
  - Push {pc, instr 0, except 1, ecode 0} and go to HALT.
- WAIT: on data_ok, push {inflight_pc, iresp_data} and go to IDLE. Space is guaranteed because issue requires count<DEPTH.
- HALT: no requests; stays in HALT until a redirect.
- Pop: when out_valid && out_ready, head advances. Push and pop in the same cycle leave count unchanged.
- Redirect has the highest priority. It sets count/head/tail to 0, pc<=redirect_pc, and the same-cycle push/pop are ignored. Next state:
  - IDLE with addr_ok and no data_ok goes to DROP. Otherwise IDLE stays IDLE.
  - WAIT with data_ok goes to IDLE with the data discarded. WAIT without data_ok goes to DROP.
  - DROP stays DROP. HALT goes to IDLE.
- DROP: ireq_valid=0. On data_ok, discard the data and go to IDLE. A redirect arriving in DROP only updates pc.
- A request presented in IDLE may be withdrawn by a redirect before addr_ok. The ibus permits this.

## Timing
- Reset values:
  - pc=RESET_PC, state IDLE, count 0.
  - out_valid=0, out_pc=0, out_instr=0, out_except=0, out_ecode=0.
  - ireq_valid=1 and ireq_addr=RESET_PC combinationally in the first cycle after reset.
- Reset mid-transaction returns to IDLE without DROP. The bus is reset together with the block.
- ireq_valid/ireq_addr are combinational from registered state only, with no path from iresp_*.
- out_* are driven from queue storage at head, with no bypass. Data_ok in cycle N gives out_valid in cycle N+1 at the earliest.
- Throughput is one instruction per cycle only with same-cycle addr_ok+data_ok. Otherwise one per two cycles plus bus latency.
- out_valid=(count!=0). Outputs are stable while out_valid && !out_ready.

## Test plan
- Reset, bus with addr_ok+data_ok every cycle, out_ready=1 -> out_pc sequence 0x80000000, 0x80000004, 0x80000008 on consecutive cycles starting one cycle after the first data_ok.
- out_ready=0, DEPTH=4, zero-wait bus -> exactly 4 entries pushed, then ireq_valid=0. Raise out_ready -> entries drain in order and issue resumes when count<4.
- Request accepted (WAIT), redirect_pc=0x80001000 asserted before data_ok, data_ok with 0xDEADBEEF 3 cycles later -> data discarded, out_valid stays 0, next ireq_addr=0x80001000.
- Redirect in the same cycle as data_ok in WAIT, with 2 entries queued -> queue empty next cycle, data discarded, state IDLE, ireq_addr=redirect_pc.
- redirect_pc=0x80000002 -> no request issued; one entry out_pc=0x80000002, out_except=1, out_ecode=0, out_instr=0. ireq_valid stays 0 until redirect to 0x80000100, which resumes fetch there.
- Reset asserted while in WAIT with 3 entries queued -> next cycle out_valid=0, ireq_addr=0x80000000, state IDLE.
